// File: rtl/snitch_ssr_cfg_sequencer.sv
// snitch_ssr_cfg_sequencer: turns SSR job descriptors into a sequence of streamer config-register writes.
module snitch_ssr_cfg_sequencer #(
  parameter int unsigned NumDims  = 4,
  parameter int unsigned NumSsrs  = 3,
  parameter int unsigned CntWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [4:0]            job_ssr_i,
  input  logic [1:0]            job_dims_i,
  input  logic                  job_write_i,
  input  logic [31:0]           job_repeat_i,
  input  logic [NumDims*32-1:0] job_bound_i,
  input  logic [NumDims*32-1:0] job_stride_i,
  input  logic [31:0]           job_ptr_i,
  output logic [11:0]           cfg_word_o,
  output logic                  cfg_write_o,
  output logic [31:0]           cfg_wdata_o,
  input  logic                  cfg_wready_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [CntWidth-1:0]   jobs_issued_o
);
  typedef enum logic [2:0] {IDLE, REPEAT, BOUND, STRIDE, PTR} state_e;
  state_e state_q, state_d;
  logic [1:0] d_q, d_d, dims_q, dims_d;
  logic [4:0] ssr_q, ssr_d;
  logic wr_q, wr_d, acc, bad;
  logic [NumDims*32-1:0] bnd_q, bnd_d, str_q, str_d;
  logic [31:0] ptr_q, ptr_d, wdata_d;
  logic [11:0] word_d;
  logic write_d, err_d;
  logic [CntWidth-1:0] cnt_d;
  assign job_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign acc = cfg_write_o && cfg_wready_i;
  assign bad = ({27'b0, job_ssr_i} >= NumSsrs && job_ssr_i != 5'd31) || {30'b0, job_dims_i} >= NumDims;
  always_comb begin
    state_d = state_q;
    d_d = d_q;
    dims_d = dims_q;
    ssr_d = ssr_q;
    wr_d = wr_q;
    bnd_d = bnd_q;
    str_d = str_q;
    ptr_d = ptr_q;
    word_d = cfg_word_o;
    wdata_d = cfg_wdata_o;
    write_d = cfg_write_o;
    err_d = err_o;
    cnt_d = jobs_issued_o;
    case (state_q)
      IDLE: if (job_valid_i) begin
        if (bad) err_d = 1'b1;
        else begin
          state_d = REPEAT;
          d_d = 2'd0;
          dims_d = job_dims_i;
          ssr_d = job_ssr_i;
          wr_d = job_write_i;
          bnd_d = job_bound_i;
          str_d = job_stride_i;
          ptr_d = job_ptr_i;
          word_d = {job_ssr_i, 2'b00, 5'd1};
          wdata_d = job_repeat_i;
          write_d = 1'b1;
        end
      end
      REPEAT: if (acc) begin
        state_d = BOUND;
        word_d = {ssr_q, 2'b00, 5'd2 + {3'b0, d_q}};
        wdata_d = bnd_q[32*d_q +: 32];
      end
      BOUND: if (acc) begin
        state_d = STRIDE;
        word_d = {ssr_q, 2'b00, 5'd6 + {3'b0, d_q}};
        wdata_d = str_q[32*d_q +: 32];
      end
      STRIDE: if (acc) begin
        if (d_q == dims_q) begin
          state_d = PTR;
          word_d = {ssr_q, 2'b00, (wr_q ? 5'd28 : 5'd24) + {3'b0, dims_q}};
          wdata_d = ptr_q;
        end else begin
          state_d = BOUND;
          d_d = d_q + 2'd1;
          word_d = {ssr_q, 2'b00, 5'd3 + {3'b0, d_q}};
          wdata_d = bnd_q[32*d_q+32 +: 32];
        end
      end
      PTR: if (acc) begin
        state_d = IDLE;
        write_d = 1'b0;
        cnt_d = jobs_issued_o + CntWidth'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      d_q <= '0;
      dims_q <= '0;
      ssr_q <= '0;
      wr_q <= 1'b0;
      bnd_q <= '0;
      str_q <= '0;
      ptr_q <= '0;
      cfg_word_o <= '0;
      cfg_wdata_o <= '0;
      cfg_write_o <= 1'b0;
      err_o <= 1'b0;
      jobs_issued_o <= '0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      dims_q <= dims_d;
      ssr_q <= ssr_d;
      wr_q <= wr_d;
      bnd_q <= bnd_d;
      str_q <= str_d;
      ptr_q <= ptr_d;
      cfg_word_o <= word_d;
      cfg_wdata_o <= wdata_d;
      cfg_write_o <= write_d;
      err_o <= err_d;
      jobs_issued_o <= cnt_d;
    end
  end
endmodule

// File: tb/tb_snitch_ssr_cfg_sequencer.sv
// tb_snitch_ssr_cfg_sequencer: directed table-driven bench for the SSR config sequencer.
module tb_snitch_ssr_cfg_sequencer;
  logic clk = 1'b0, rst = 1'b1, va = 1'b0, vb = 1'b0, wready = 1'b1;
  logic [4:0] job_ssr = '0;
  logic [1:0] job_dims = '0;
  logic job_write = 1'b0;
  logic [31:0] job_repeat = '0, job_ptr = '0;
  logic [127:0] job_bound = '0, job_stride = '0;
  logic a_ready, a_write, a_busy, a_err, b_ready, b_write, b_busy, b_err;
  logic [11:0] a_word, b_word;
  logic [31:0] a_wdata, b_wdata;
  logic [15:0] a_cnt;
  logic [3:0] b_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [11:0] qw[$];
  logic [31:0] qd[$];
  always #5 clk = ~clk;
  snitch_ssr_cfg_sequencer dut_a (
    .clk_i(clk), .rst_i(rst), .job_valid_i(va), .job_ready_o(a_ready),
    .job_ssr_i(job_ssr), .job_dims_i(job_dims), .job_write_i(job_write),
    .job_repeat_i(job_repeat), .job_bound_i(job_bound), .job_stride_i(job_stride),
    .job_ptr_i(job_ptr), .cfg_word_o(a_word), .cfg_write_o(a_write),
    .cfg_wdata_o(a_wdata), .cfg_wready_i(wready), .busy_o(a_busy), .err_o(a_err),
    .jobs_issued_o(a_cnt)
  );
  snitch_ssr_cfg_sequencer #(.NumDims(2), .CntWidth(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .job_valid_i(vb), .job_ready_o(b_ready),
    .job_ssr_i(job_ssr), .job_dims_i(job_dims), .job_write_i(job_write),
    .job_repeat_i(job_repeat), .job_bound_i(job_bound[63:0]), .job_stride_i(job_stride[63:0]),
    .job_ptr_i(job_ptr), .cfg_word_o(b_word), .cfg_write_o(b_write),
    .cfg_wdata_o(b_wdata), .cfg_wready_i(1'b1), .busy_o(b_busy), .err_o(b_err),
    .jobs_issued_o(b_cnt)
  );
  typedef struct {
    logic [4:0] ssr; logic [1:0] dims; logic wr; logic [31:0] rep;
    logic [127:0] bnd; logic [127:0] str; logic [31:0] ptr;
    int n_wr; logic [11:0] last_word; logic [31:0] last_data; logic err; int issued;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    job_ssr = v.ssr; job_dims = v.dims; job_write = v.wr; job_repeat = v.rep;
    job_bound = v.bnd; job_stride = v.str; job_ptr = v.ptr;
  endtask
  task automatic run_a(input vec_t v, input int stall_at, input int stall_len, output int n_busy, output int n_hold);
    int stalls;
    qw.delete(); qd.delete();
    n_busy = 0; n_hold = 0; stalls = 0;
    @(negedge clk); drive(v); va = 1'b1; wready = 1'b1;
    @(negedge clk); va = 1'b0;
    for (int t = 0; t < 60 && a_busy; t++) begin
      n_busy++;
      if (a_word == 12'h086 && a_write) n_hold++;
      wready = !(qw.size() == stall_at && stalls < stall_len);
      if (!wready) stalls++;
      if (a_write && wready) begin qw.push_back(a_word); qd.push_back(a_wdata); end
      @(negedge clk);
    end
    wready = 1'b1;
    chk("returned_idle", a_busy, 0);
    chk("no_write_in_idle", a_write, 0);
  endtask
  initial begin
    int nb, nh, cyc, acc;
    logic [11:0] ew[6];
    logic [31:0] ed[6];
    ew = '{12'h081, 12'h082, 12'h086, 12'h083, 12'h087, 12'h099};
    ed = '{32'd0, 32'd7, 32'd8, 32'd3, 32'd64, 32'h1000};
    tbl[0] = '{5'd1, 2'd1, 1'b0, 32'd0, {64'd0, 32'd3, 32'd7}, {64'd0, 32'd64, 32'd8}, 32'h1000, 6, 12'h099, 32'h1000, 1'b0, 1};
    tbl[1] = '{5'd31, 2'd3, 1'b1, 32'd5, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd16, 32'd12, 32'd8, 32'd4}, 32'h2000, 10, 12'hF9F, 32'h2000, 1'b0, 2};
    tbl[2] = '{5'd0, 2'd0, 1'b0, 32'd9, {96'd0, 32'd15}, {96'd0, 32'd4}, 32'h40, 4, 12'h018, 32'h40, 1'b0, 3};
    tbl[3] = '{5'd2, 2'd2, 1'b1, 32'd1, {32'd0, 32'd9, 32'd8, 32'd7}, {32'd0, 32'd3, 32'd2, 32'd1}, 32'hABC, 8, 12'h11E, 32'hABC, 1'b0, 4};
    tbl[4] = '{5'd5, 2'd1, 1'b0, 32'd0, 128'd1, 128'd1, 32'h10, 0, 12'h0, 32'h0, 1'b1, 4};
    tbl[5] = '{5'd3, 2'd0, 1'b1, 32'd0, 128'd1, 128'd1, 32'h10, 0, 12'h0, 32'h0, 1'b1, 4};
    tbl[6] = '{5'd30, 2'd2, 1'b0, 32'd0, 128'd1, 128'd1, 32'h10, 0, 12'h0, 32'h0, 1'b1, 4};
    tbl[7] = '{5'd31, 2'd0, 1'b0, 32'd2, {96'd0, 32'd1}, {96'd0, 32'd2}, 32'h77, 4, 12'hF98, 32'h77, 1'b1, 5};
    repeat (2) @(negedge clk);
    chk("rst_ready", a_ready, 1); chk("rst_write", a_write, 0); chk("rst_word", a_word, 0);
    chk("rst_wdata", a_wdata, 0); chk("rst_busy", a_busy, 0); chk("rst_err", a_err, 0); chk("rst_cnt", a_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", a_ready, 1); chk("post_rst_busy", a_busy, 0);
    for (int i = 0; i < 8; i++) begin
      run_a(tbl[i], -1, 0, nb, nh);
      chk($sformatf("v%0d_nwr", i), qw.size(), tbl[i].n_wr);
      chk($sformatf("v%0d_busy", i), nb, tbl[i].n_wr);
      chk($sformatf("v%0d_last_word", i), qw.size() > 0 ? 32'(qw[qw.size()-1]) : 32'h0, 32'(tbl[i].last_word));
      chk($sformatf("v%0d_last_data", i), qw.size() > 0 ? qd[qd.size()-1] : 32'h0, tbl[i].last_data);
      chk($sformatf("v%0d_err", i), a_err, tbl[i].err);
      chk($sformatf("v%0d_cnt", i), a_cnt, tbl[i].issued);
      chk($sformatf("v%0d_ready", i), a_ready, 1);
      for (int k = 0; k < qw.size(); k++) chk($sformatf("v%0d_lane%0d", i, k), qw[k][11:7], tbl[i].ssr);
    end
    run_a(tbl[0], -1, 0, nb, nh);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("seq_word%0d", k), k < qw.size() ? 32'(qw[k]) : 32'hFFF, 32'(ew[k]));
      chk($sformatf("seq_data%0d", k), k < qd.size() ? qd[k] : 32'hDEAD, ed[k]);
    end
    run_a(tbl[0], 2, 3, nb, nh);
    chk("bp_busy", nb, 9);
    chk("bp_hold", nh, 4);
    for (int k = 0; k < 6; k++) chk($sformatf("bp_word%0d", k), k < qw.size() ? 32'(qw[k]) : 32'hFFF, 32'(ew[k]));
    chk("bp_stride_data", qd.size() > 2 ? qd[2] : 32'hDEAD, 32'd8);
    @(negedge clk); drive(tbl[0]); va = 1'b1;
    @(negedge clk); va = 1'b0;
    cyc = 0;
    while (a_word != 12'h083 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rst_mid_reached_bound1", a_word, 12'h083);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_write", a_write, 0);
    chk("rst_mid_busy", a_busy, 0);
    @(negedge clk); rst = 1'b0;
    nh = 0;
    repeat (4) begin @(negedge clk); if (a_write) nh++; end
    chk("rst_no_ptr_write", nh, 0);
    chk("rst_cnt_cleared", a_cnt, 0);
    run_a(tbl[0], -1, 0, nb, nh);
    chk("after_rst_first_word", qw.size() > 0 ? 32'(qw[0]) : 32'hFFF, 32'h081);
    chk("after_rst_nwr", qw.size(), 6);
    chk("after_rst_cnt", a_cnt, 1);
    @(negedge clk); job_ssr = 5'd0; job_dims = 2'd3; vb = 1'b1;
    @(negedge clk); vb = 1'b0;
    chk("b_bad_dims_err", b_err, 1); chk("b_bad_dims_write", b_write, 0);
    chk("b_bad_dims_ready", b_ready, 1); chk("b_bad_dims_cnt", b_cnt, 0);
    drive(tbl[2]); vb = 1'b1;
    cyc = 0; acc = 1;
    while (acc < 17 && cyc < 200) begin @(negedge clk); cyc++; if (b_ready) acc++; end
    @(posedge clk); #1 vb = 1'b0;
    chk("wrap_spacing", cyc, 80);
    cyc = 0;
    while ((b_busy || cyc == 0) && cyc < 20) begin @(negedge clk); cyc++; end
    chk("wrap_idle", b_busy, 0);
    chk("wrap_cnt", b_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
